mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Memory stage of the RV32I core. It sits directly downstream of ex and consumes its per-instruction result: ALU writeback data, or a load/store request. Loads and stores are issued on a req/gnt/rvalid data bus, with byte-lane steering and load sign/zero extension. It produces one registered writeback record per accepted instruction and back-pressures ex while a bus access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, bus wait limit in cycles for gnt or rvalid; 0 disables the timeout.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
flush_i  in  1  kill the instruction presented this cycle, or suppress writeback of the in-flight one
ex_valid_i  in  1  ex presents an instruction
ex_ready_o  out  1  lsu accepts this cycle (high only in IDLE)
stall_o  out  1  hold request to upstream; equals !ex_ready_o
ex_mem_re_i  in  1  instruction is a load
ex_mem_we_i  in  1  instruction is a store
ex_funct3_i  in  3  access width/sign (inst[14:12])
ex_addr_i  in  32  effective address
ex_wdata_i  in  32  store data (rs2)
ex_rd_i  in  5  destination register
ex_reg_we_i  in  1  non-memory register write enable
ex_reg_wdata_i  in  32  non-memory result
bus_req_o  out  1  bus request
bus_we_o  out  1  1 = write
bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
bus_wdata_o  out  32  lane-shifted store data
bus_wstrb_o  out  4  byte strobes
bus_gnt_i  in  1  request accepted
bus_rvalid_i  in  1  read data valid
bus_rdata_i  in  32  read data
wb_valid_o  out  1  writeback record valid (1-cycle pulse)
wb_we_o  out  1  regfile write enable
wb_rd_o  out  5  regfile address
wb_wdata_o  out  32  regfile data
lsu_err_o  out  1  misaligned / illegal funct3 / timeout (1-cycle pulse, same cycle as wb_valid_o)
lsu_err_addr_o  out  32  faulting address

Behaviour:
- Reset: state IDLE; all outputs 0, except ex_ready_o=1 and stall_o=0. Timeout counter 0. Reset mid-transaction drops the request immediately; no writeback follows.
- Accept: a handshake occurs when ex_valid_i && ex_ready_o && !flush_i. When flush_i is high in IDLE, nothing is captured.
- Non-memory instruction (re=we=0): captured at edge N. At N+1, wb_valid_o=1 with we/rd/data taken from ex_* and lsu_err_o=0. Stays in IDLE, so back-to-back issue runs at one per cycle.
- Both re and we high: treated as illegal.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal funct3 for stores: 000, 001, 010. Any other value is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- Illegal or misaligned access: no bus activity. Next cycle: wb_valid_o=1, wb_we_o=0, lsu_err_o=1, lsu_err_addr_o=ex_addr_i.
- FSM states: IDLE, REQ, RWAIT.
  - IDLE -> REQ on a legal memory accept. bus_* are registered and driven from the next cycle.
  - REQ: bus_req_o and all bus_* held stable until bus_gnt_i=1.
    - Store, on gnt: go to IDLE; the next cycle wb_valid_o=1 with wb_we_o=0.
    - Load, on gnt: go to RWAIT, deassert bus_req_o.
  - RWAIT: on bus_rvalid_i, extract the lane and extend; the next cycle wb_valid_o=1, wb_we_o=1 (0 if rd=0), wb_wdata_o=result; return to IDLE.
- rvalid in the same cycle as gnt is not legal bus behaviour. The lsu ignores rvalid while in REQ.
- Store steering: SB replicates byte to all lanes, strb=1<<addr[1:0]. SH replicates halfword, strb=0011 or 1100 by addr[1]. SW strb=1111.
- Load extraction: byte = rdata>>(8*addr[1:0]); half = rdata>>(16*addr[1]). LB/LH sign-extend; LBU/LHU zero-extend.
- Flush while in REQ or RWAIT: the bus transaction completes normally, but the resulting wb_valid_o is suppressed and the FSM returns to IDLE.
- Timeout: the counter increments each cycle in REQ/RWAIT and clears on state exit. On reaching TIMEOUT_CYCLES (when nonzero): bus_req_o drops, error writeback as for misalign, FSM returns to IDLE. Any late rvalid arriving in IDLE is ignored.
- Latency, accept to wb_valid_o:
  - ALU op: 1 cycle.
  - Store with gnt on first REQ cycle: 2 cycles.
  - Load with gnt and then rvalid each one cycle later: 3 cycles.

Test Plan:
- ALU stream: 3 back-to-back non-mem ops, rd=1,2,3, data 0x11/0x22/0x33 -> wb pulses on 3 consecutive cycles, each 1 cycle after its accept; stall_o stays 0.
- SB addr 0x1003, wdata 0x000000A5, gnt delayed 2 cycles -> bus_req held 3 cycles, addr 0x1000, wdata 0xA5A5A5A5, wstrb 1000; wb_valid with we=0 on the cycle after gnt.
- LB addr 0x2002, rdata 0x00800000 -> wb_wdata 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x2002, rdata 0xBEEF0000 -> 0x0000BEEF.
- LW addr 0x3001 -> no bus_req, next cycle lsu_err=1, lsu_err_addr=0x3001, wb_we=0. Same result for funct3=011.
- Load issued, flush_i pulsed in RWAIT, rvalid arrives later -> no wb_valid; ex_ready returns to 1 the cycle after rvalid.
- TIMEOUT_CYCLES=4, gnt never asserted -> bus_req drops after 4 REQ cycles, lsu_err=1. Separately, rst asserted mid-REQ -> bus_req=0 immediately, no wb.

Source files
------------

// File: rtl/mem_lsu.sv
// Memory stage of the RV32I core: turns ex results into writeback records and runs
// loads/stores over a req/gnt/rvalid bus with byte-lane steering and load extension.
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    output logic        stall_o,
    input  logic        ex_mem_re_i,
    input  logic        ex_mem_we_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_reg_we_i,
    input  logic [31:0] ex_reg_wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_wdata_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_err_addr_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] RWAIT = 2'd2;

    logic [1:0]  state;
    logic [31:0] tcnt;
    logic        cap_load;
    logic [2:0]  cap_f3;
    logic [31:0] cap_addr;
    logic [4:0]  cap_rd;
    logic        killed;

    logic        accept;
    logic        is_mem;
    logic        f3_ok;
    logic        misaligned;
    logic        mem_err;
    logic        timed_out;
    logic        kill;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    assign ex_ready_o = (state == IDLE);
    assign stall_o    = !ex_ready_o;
    assign accept     = ex_valid_i && ex_ready_o && !flush_i;
    assign is_mem     = ex_mem_re_i || ex_mem_we_i;
    assign kill       = killed || flush_i;
    assign timed_out  = (TIMEOUT_CYCLES != 0) && (tcnt == 32'(TIMEOUT_CYCLES - 1));

    // Decode legality, alignment and store lane steering for the instruction offered by ex
    always_comb begin
        f3_ok      = 1'b0;
        misaligned = 1'b0;
        st_data    = ex_wdata_i;
        st_strb    = 4'b1111;
        if (ex_mem_re_i)
            f3_ok = (ex_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else
            f3_ok = (ex_funct3_i inside {3'b000, 3'b001, 3'b010});
        if (ex_funct3_i[1:0] == 2'b01)
            misaligned = ex_addr_i[0];
        else if (ex_funct3_i[1:0] == 2'b10)
            misaligned = (ex_addr_i[1:0] != 2'b00);
        case (ex_funct3_i[1:0])
            2'b00: begin
                st_data = {4{ex_wdata_i[7:0]}};
                st_strb = 4'b0001 << ex_addr_i[1:0];
            end
            2'b01: begin
                st_data = {2{ex_wdata_i[15:0]}};
                st_strb = ex_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = ex_wdata_i;
                st_strb = 4'b1111;
            end
        endcase
    end

    assign mem_err = is_mem && ((ex_mem_re_i && ex_mem_we_i) || !f3_ok || misaligned);

    // Load lane extraction uses the offset captured at accept time
    always_comb begin
        ld_shift = bus_rdata_i >> {cap_addr[1:0], 3'b000};
        ld_data  = bus_rdata_i;
        case (cap_f3)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'd0, ld_shift[7:0]};
            3'b101:  ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tcnt           <= '0;
            cap_load       <= 1'b0;
            cap_f3         <= '0;
            cap_addr       <= '0;
            cap_rd         <= '0;
            killed         <= 1'b0;
            bus_req_o      <= 1'b0;
            bus_we_o       <= 1'b0;
            bus_addr_o     <= '0;
            bus_wdata_o    <= '0;
            bus_wstrb_o    <= '0;
            wb_valid_o     <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_rd_o        <= '0;
            wb_wdata_o     <= '0;
            lsu_err_o      <= 1'b0;
            lsu_err_addr_o <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            lsu_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wb_rd_o <= ex_rd_i;
                        if (!is_mem) begin
                            wb_valid_o <= 1'b1;
                            wb_we_o    <= ex_reg_we_i;
                            wb_wdata_o <= ex_reg_wdata_i;
                        end else if (mem_err) begin
                            wb_valid_o     <= 1'b1;
                            wb_we_o        <= 1'b0;
                            wb_wdata_o     <= '0;
                            lsu_err_o      <= 1'b1;
                            lsu_err_addr_o <= ex_addr_i;
                        end else begin
                            state       <= REQ;
                            tcnt        <= '0;
                            killed      <= 1'b0;
                            cap_load    <= ex_mem_re_i;
                            cap_f3      <= ex_funct3_i;
                            cap_addr    <= ex_addr_i;
                            cap_rd      <= ex_rd_i;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= ex_mem_we_i;
                            bus_addr_o  <= {ex_addr_i[31:2], 2'b00};
                            bus_wdata_o <= ex_mem_we_i ? st_data : 32'd0;
                            bus_wstrb_o <= ex_mem_we_i ? st_strb : 4'b0000;
                        end
                    end
                end
                REQ, RWAIT: begin
                    killed <= kill;
                    tcnt   <= tcnt + 32'd1;
                    wb_rd_o <= cap_rd;
                    // rvalid is only meaningful once the request has been granted
                    if ((state == REQ) && bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        tcnt      <= '0;
                        if (cap_load) begin
                            state <= RWAIT;
                        end else begin
                            state      <= IDLE;
                            wb_valid_o <= !kill;
                            wb_we_o    <= 1'b0;
                            wb_wdata_o <= '0;
                        end
                    end else if ((state == RWAIT) && bus_rvalid_i) begin
                        state      <= IDLE;
                        tcnt       <= '0;
                        wb_valid_o <= !kill;
                        wb_we_o    <= (cap_rd != 5'd0);
                        wb_wdata_o <= ld_data;
                    end else if (timed_out) begin
                        state          <= IDLE;
                        tcnt           <= '0;
                        bus_req_o      <= 1'b0;
                        wb_valid_o     <= !kill;
                        wb_we_o        <= 1'b0;
                        wb_wdata_o     <= '0;
                        lsu_err_o      <= !kill;
                        lsu_err_addr_o <= cap_addr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus randomized bench for mem_lsu; expected results come from an
// arithmetic model of the load/store rules kept in this file.
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic        stall_o;
    logic        ex_mem_re_i;
    logic        ex_mem_we_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic [4:0]  ex_rd_i;
    logic        ex_reg_we_i;
    logic [31:0] ex_reg_wdata_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_wdata_o;
    logic        lsu_err_o;
    logic [31:0] lsu_err_addr_o;

    int total;
    int bad;

    mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .stall_o(stall_o),
        .ex_mem_re_i(ex_mem_re_i), .ex_mem_we_i(ex_mem_we_i), .ex_funct3_i(ex_funct3_i),
        .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_rd_i(ex_rd_i),
        .ex_reg_we_i(ex_reg_we_i), .ex_reg_wdata_i(ex_reg_wdata_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
        .wb_wdata_o(wb_wdata_o), .lsu_err_o(lsu_err_o), .lsu_err_addr_o(lsu_err_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic re, input logic we,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input logic regWe, input logic [31:0] regWdata);
        ex_valid_i     = valid;
        ex_mem_re_i    = re;
        ex_mem_we_i    = we;
        ex_funct3_i    = f3;
        ex_addr_i      = addr;
        ex_wdata_i     = wdata;
        ex_rd_i        = rd;
        ex_reg_we_i    = regWe;
        ex_reg_wdata_i = regWdata;
    endtask

    // Reference model: access size, legality, lane placement and extension
    function automatic int accBytes(input logic [2:0] f3);
        int low = int'(f3) % 4;
        if (low == 0) return 1;
        if (low == 1) return 2;
        return 4;
    endfunction

    function automatic bit modelLegal(input logic re, input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr);
        int n = accBytes(f3);
        if (re && we) return 1'b0;
        if (re && !(int'(f3) inside {0, 1, 2, 4, 5})) return 1'b0;
        if (we && !(int'(f3) inside {0, 1, 2})) return 1'b0;
        return (int'(addr % 4) % n) == 0;
    endfunction

    function automatic logic [3:0] modelStrb(input logic [2:0] f3, input logic [31:0] addr);
        int n = accBytes(f3);
        int s = ((1 << n) - 1) << int'(addr % 4);
        return s[3:0];
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
        int n = accBytes(f3);
        if (n == 1) return (wd & 32'hFF) * 32'h01010101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        int n = accBytes(f3);
        longint span = longint'(1) << (8 * n);
        longint v = (longint'(rdata) >> (8 * int'(addr % 4))) & (span - 1);
        if (int'(f3) < 4 && n < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic aluOp(input logic [4:0] rd, input logic regWe, input logic [31:0] data);
        applyStimulus(1, 0, 0, 3'd0, 32'd0, 32'd0, rd, regWe, data);
        tick();
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
        checkOutput("alu_wb_valid", wb_valid_o, 1'b1);
        checkOutput("alu_wb_we", wb_we_o, regWe);
        checkWord("alu_wb_rd", 32'(wb_rd_o), 32'(rd));
        checkWord("alu_wb_wdata", wb_wdata_o, data);
        checkOutput("alu_stall", stall_o, 1'b0);
    endtask

    task automatic memOp(input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input int gntDelay, input int rvDelay, input logic [31:0] rdata);
        applyStimulus(1, re, we, f3, addr, wdata, rd, 0, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
        if (!modelLegal(re, we, f3, addr)) begin
            checkOutput("err_bus_req", bus_req_o, 1'b0);
            checkOutput("err_wb_valid", wb_valid_o, 1'b1);
            checkOutput("err_wb_we", wb_we_o, 1'b0);
            checkOutput("err_flag", lsu_err_o, 1'b1);
            checkWord("err_addr", lsu_err_addr_o, addr);
            return;
        end
        for (int i = 0; i <= gntDelay; i++) begin
            checkOutput("req_held", bus_req_o, 1'b1);
            checkOutput("req_stall", stall_o, 1'b1);
            checkOutput("req_we", bus_we_o, we);
            checkWord("req_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
            if (we) begin
                checkWord("req_wdata", bus_wdata_o, modelWdata(f3, wdata));
                checkWord("req_wstrb", 32'(bus_wstrb_o), 32'(modelStrb(f3, addr)));
            end
            bus_gnt_i = (i == gntDelay);
            tick();
        end
        bus_gnt_i = 1'b0;
        checkOutput("gnt_req_drop", bus_req_o, 1'b0);
        if (we) begin
            checkOutput("st_wb_valid", wb_valid_o, 1'b1);
            checkOutput("st_wb_we", wb_we_o, 1'b0);
            checkOutput("st_err", lsu_err_o, 1'b0);
        end else begin
            checkOutput("ld_wait_wb", wb_valid_o, 1'b0);
            for (int j = 0; j <= rvDelay; j++) begin
                bus_rvalid_i = (j == rvDelay);
                bus_rdata_i  = (j == rvDelay) ? rdata : 32'hDEAD_BEEF;
                tick();
            end
            bus_rvalid_i = 1'b0;
            checkOutput("ld_wb_valid", wb_valid_o, 1'b1);
            checkOutput("ld_wb_we", wb_we_o, rd != 5'd0);
            checkWord("ld_wb_rd", 32'(wb_rd_o), 32'(rd));
            checkWord("ld_wb_wdata", wb_wdata_o, modelLoad(f3, addr, rdata));
            checkOutput("ld_err", lsu_err_o, 1'b0);
        end
        checkOutput("done_ready", ex_ready_o, 1'b1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        flush_i = 1'b0;
        bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i = 32'd0;
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_ready", ex_ready_o, 1'b1);
        checkOutput("rst_stall", stall_o, 1'b0);
        checkOutput("rst_req", bus_req_o, 1'b0);
        checkOutput("rst_wb_valid", wb_valid_o, 1'b0);
        checkOutput("rst_err", lsu_err_o, 1'b0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Back-to-back ALU stream, one writeback per cycle
        aluOp(5'd1, 1'b1, 32'h11);
        aluOp(5'd2, 1'b1, 32'h22);
        aluOp(5'd3, 1'b1, 32'h33);
        tick();
        checkOutput("alu_idle_wb", wb_valid_o, 1'b0);

        // Flush in IDLE captures nothing
        flush_i = 1'b1;
        applyStimulus(1, 0, 0, 3'd0, 32'd0, 32'd0, 5'd4, 1, 32'h44);
        tick();
        flush_i = 1'b0;
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
        checkOutput("flush_idle_wb", wb_valid_o, 1'b0);

        memOp(0, 1, 3'd0, 32'h1003, 32'h0000_00A5, 5'd5, 2, 0, 32'd0);
        memOp(1, 0, 3'd0, 32'h2002, 32'd0, 5'd7, 0, 0, 32'h0080_0000);
        memOp(1, 0, 3'd4, 32'h2002, 32'd0, 5'd7, 0, 0, 32'h0080_0000);
        memOp(1, 0, 3'd5, 32'h2002, 32'd0, 5'd8, 0, 0, 32'hBEEF_0000);
        memOp(1, 0, 3'd2, 32'h3001, 32'd0, 5'd9, 0, 0, 32'd0);
        memOp(1, 0, 3'd3, 32'h3001, 32'd0, 5'd9, 0, 0, 32'd0);
        memOp(1, 1, 3'd2, 32'h3000, 32'd0, 5'd9, 0, 0, 32'd0);
        memOp(0, 1, 3'd1, 32'h1002, 32'h1234_5678, 5'd0, 0, 0, 32'd0);

        // Flush while waiting for read data suppresses the writeback
        applyStimulus(1, 1, 0, 3'd2, 32'h40, 32'd0, 5'd6, 0, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        checkOutput("fl_req_drop", bus_req_o, 1'b0);
        checkOutput("fl_rwait_ready", ex_ready_o, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i = 32'hCAFE_F00D;
        tick();
        bus_rvalid_i = 1'b0;
        checkOutput("fl_wb_valid", wb_valid_o, 1'b0);
        checkOutput("fl_ready", ex_ready_o, 1'b1);

        // Grant never arrives: request drops after four REQ cycles with an error
        applyStimulus(1, 0, 1, 3'd2, 32'h500, 32'h1, 5'd3, 0, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("to_req_held", bus_req_o, 1'b1);
            tick();
        end
        checkOutput("to_req_drop", bus_req_o, 1'b0);
        checkOutput("to_wb_valid", wb_valid_o, 1'b1);
        checkOutput("to_wb_we", wb_we_o, 1'b0);
        checkOutput("to_err", lsu_err_o, 1'b1);
        checkWord("to_err_addr", lsu_err_addr_o, 32'h500);
        bus_rvalid_i = 1'b1;
        tick();
        bus_rvalid_i = 1'b0;
        checkOutput("late_rvalid_wb", wb_valid_o, 1'b0);

        // Reset in the middle of a request
        applyStimulus(1, 1, 0, 3'd2, 32'h100, 32'd0, 5'd2, 0, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
        checkOutput("mid_req", bus_req_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_req", bus_req_o, 1'b0);
        checkOutput("mid_rst_ready", ex_ready_o, 1'b1);
        tick();
        checkOutput("mid_rst_wb", wb_valid_o, 1'b0);
        @(negedge clk) rst = 1'b0;
        tick();
        checkOutput("post_rst_wb", wb_valid_o, 1'b0);

        // Randomized mix against the model
        for (int k = 0; k < 40; k++) begin
            int kind = $urandom_range(0, 3);
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] addr = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rdv = $urandom;
            logic [4:0]  rd = 5'($urandom_range(0, 31));
            if (kind == 0)
                aluOp(rd, 1'($urandom_range(0, 1)), wd);
            else
                memOp(kind != 2, kind != 1, f3, addr, wd, rd,
                      $urandom_range(0, 2), $urandom_range(0, 2), rdv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
